// File: rtl/rfs_access_arbiter.sv
// Two-requester round-robin arbiter in front of a shared register file.
// Each access: IDLE -> ISSUE (strobe) -> optional WAIT (bounded by TIMEOUT) -> DONE (ack).
module rfs_access_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       res,
  input  logic       a_req,
  input  logic       a_we,
  input  logic [4:0] a_addr,
  input  logic [7:0] a_wdata,
  output logic       a_ack,
  output logic [7:0] a_rdata,
  output logic       a_err,
  input  logic       b_req,
  input  logic       b_we,
  input  logic [4:0] b_addr,
  input  logic [7:0] b_wdata,
  output logic       b_ack,
  output logic [7:0] b_rdata,
  output logic       b_err,
  output logic [4:0] rf_address,
  output logic [7:0] rf_write_data,
  output logic       rf_write_en,
  output logic       rf_read_en,
  input  logic [7:0] rf_read_data,
  input  logic       rf_access_complete,
  input  logic       rf_invalid_address,
  output logic       busy,
  output logic       grant_id
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t     r_state, w_state_nxt;
  logic       r_gid, r_we, r_err;
  logic [4:0] r_addr;
  logic [7:0] r_wdata, r_rdata, r_cnt;
  logic       w_grant, w_win, w_cap, w_tmo, w_done;

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_win       = r_gid;
    w_cap       = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      S_IDLE: if (a_req || b_req) begin
        w_grant     = 1'b1;
        // on a tie the requester not served last wins
        w_win       = (a_req && b_req) ? ~r_gid : b_req;
        w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        w_cap       = rf_access_complete;
        w_state_nxt = rf_access_complete ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (rf_access_complete) begin
          w_cap       = 1'b1;
          w_state_nxt = S_DONE;
        end else if (r_cnt == TMO_LAST) begin
          w_tmo       = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      r_state <= S_IDLE;
      r_gid   <= 1'b1;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_gid   <= w_win;
        r_we    <= w_win ? b_we    : a_we;
        r_addr  <= w_win ? b_addr  : a_addr;
        r_wdata <= w_win ? b_wdata : a_wdata;
      end
      if (w_cap) begin
        r_rdata <= r_we ? 8'h00 : rf_read_data;
        r_err   <= rf_invalid_address;
      end else if (w_tmo) begin
        r_rdata <= 8'h00;
        r_err   <= 1'b1;
      end
      // counter is zero on the first WAIT cycle
      if (r_state == S_ISSUE)     r_cnt <= '0;
      else if (r_state == S_WAIT) r_cnt <= r_cnt + 8'd1;
    end
  end

  assign w_done        = (r_state == S_DONE);
  assign a_ack         = w_done & ~r_gid;
  assign b_ack         = w_done &  r_gid;
  assign a_rdata       = a_ack ? r_rdata : 8'h00;
  assign a_err         = a_ack & r_err;
  assign b_rdata       = b_ack ? r_rdata : 8'h00;
  assign b_err         = b_ack & r_err;
  assign rf_write_en   = (r_state == S_ISSUE) &  r_we;
  assign rf_read_en    = (r_state == S_ISSUE) & ~r_we;
  assign rf_address    = r_addr;
  assign rf_write_data = r_wdata;
  assign busy          = (r_state != S_IDLE);
  assign grant_id      = r_gid;

endmodule
